// File: rtl/prob_table_sequencer.sv
// ---------------------------------------------------------------------------
// prob_table_sequencer
//
// Upstream control stage for the parallel simulator. It holds a host-written
// table of noise probabilities and, on start, runs the simulator through its
// load/run sequence without any bench involvement:
//   IDLE -> RESET (simulator held in reset for RST_CYCLES cycles)
//        -> LOAD  (one table entry per cycle on probability_idx/probability_in)
//        -> PARK  (index parked for one cycle)
//        -> RUN   (simulator enabled until the target frame count is reached)
//        -> DONE  (simulator stopped but kept out of reset so its counters
//                  stay readable; start begins the next sweep point)
//
// Ports
//   clk, rstn         system clock, asynchronous active-low reset
//   host_wr_*         valid/ready table write port (blocked during LOAD only)
//   start, abort      one-cycle control pulses (abort wins over start)
//   target_frames     frame target, latched on an accepted start (0 = no limit)
//   total_frames      frame counter reported back by the simulator
//   probability_idx   table write index to the simulator (IDX_PARK when idle)
//   probability_in    table write data to the simulator
//   sim_en, sim_rstn  simulator enable and active-low synchronous reset
//   busy, done        status: busy in RESET/LOAD/PARK/RUN, done in DONE
// All outputs are registered.
// ---------------------------------------------------------------------------
module prob_table_sequencer #(
    parameter int          N_ENTRIES  = 64,
    parameter int          RST_CYCLES = 4,
    parameter logic [31:0] IDX_PARK   = 32'hFFFF_FFFF,
    localparam int         AW         = $clog2(N_ENTRIES)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          host_wr_valid,
    output logic          host_wr_ready,
    input  logic [AW-1:0] host_wr_addr,
    input  logic [63:0]   host_wr_data,
    input  logic          start,
    input  logic          abort,
    input  logic [63:0]   target_frames,
    input  logic [63:0]   total_frames,
    output logic [31:0]   probability_idx,
    output logic [63:0]   probability_in,
    output logic          sim_en,
    output logic          sim_rstn,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_LOAD,
        S_PARK,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [31:0]   cnt;
    logic [63:0]   target_q;
    logic [63:0]   table_mem [N_ENTRIES];
    logic [AW-1:0] rd_addr;
    logic          write_fire;

    assign write_fire = host_wr_valid && host_wr_ready;

    // Table storage is deliberately not reset: a host may preload it once and
    // reuse it across several sweep points.
    always_ff @(posedge clk) begin
        if (write_fire) begin
            table_mem[host_wr_addr] <= host_wr_data;
        end
    end

    // Outputs are registered, so the entry to present in the next LOAD cycle
    // is fetched one cycle ahead: entry 0 while leaving RESET, cnt+1 in LOAD.
    always_comb begin
        rd_addr = '0;
        if (state == S_LOAD) begin
            rd_addr = cnt[AW-1:0] + AW'(1);
        end
    end

    // Sequencer FSM. Each transition also sets the registered outputs for
    // the state being entered, so outputs always match the current state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= S_IDLE;
            cnt             <= '0;
            target_q        <= '0;
            probability_idx <= IDX_PARK;
            probability_in  <= '0;
            sim_en          <= 1'b0;
            sim_rstn        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            host_wr_ready   <= 1'b1;
        end else if (abort) begin
            // probability_in keeps its last value; only the index parks.
            state           <= S_IDLE;
            probability_idx <= IDX_PARK;
            sim_en          <= 1'b0;
            sim_rstn        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            host_wr_ready   <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RESET;
                        target_q <= target_frames;
                        cnt      <= '0;
                        sim_en   <= 1'b0;
                        sim_rstn <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (cnt == 32'(RST_CYCLES - 1)) begin
                        state           <= S_LOAD;
                        cnt             <= '0;
                        probability_idx <= '0;
                        probability_in  <= table_mem[rd_addr];
                        host_wr_ready   <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_LOAD: begin
                    if (cnt == 32'(N_ENTRIES - 1)) begin
                        state           <= S_PARK;
                        probability_idx <= IDX_PARK;
                        host_wr_ready   <= 1'b1;
                    end else begin
                        cnt             <= cnt + 32'd1;
                        probability_idx <= cnt + 32'd1;
                        probability_in  <= table_mem[rd_addr];
                    end
                end
                S_PARK: begin
                    state    <= S_RUN;
                    sim_en   <= 1'b1;
                    sim_rstn <= 1'b1;
                end
                S_RUN: begin
                    // A zero target means run until abort.
                    if ((target_q != 64'd0) && (total_frames >= target_q)) begin
                        state  <= S_DONE;
                        sim_en <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prob_table_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prob_table_sequencer
//
// Self-checking bench for prob_table_sequencer. Expected behaviour comes from
// a timeline model: for a start pulse at offset 0, offsets 1..RST are the
// reset window, the next N offsets are the load window (entry = offset-1-RST),
// one park offset follows and the run begins at offset 1+RST+N+1. The table
// contents are mirrored in ref_table. Outputs are sampled and inputs driven
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_prob_table_sequencer;

    localparam int          N    = 64;
    localparam int          RST  = 4;
    localparam logic [31:0] PARK = 32'hFFFF_FFFF;
    localparam int          RUN_T = 1 + RST + N + 1;

    // Status vector order: {sim_en, sim_rstn, busy, done, host_wr_ready}
    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_RUN  = 5'b11101;
    localparam logic [4:0] ST_DONE = 5'b01011;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        host_wr_valid = 1'b0;
    logic        host_wr_ready;
    logic [5:0]  host_wr_addr = '0;
    logic [63:0] host_wr_data = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] target_frames = '0;
    logic [63:0] total_frames = '0;
    logic [31:0] probability_idx;
    logic [63:0] probability_in;
    logic        sim_en;
    logic        sim_rstn;
    logic        busy;
    logic        done;

    logic [4:0]  status;
    logic [63:0] ref_table [N];
    int          checks = 0;
    int          failures = 0;

    assign status = {sim_en, sim_rstn, busy, done, host_wr_ready};

    prob_table_sequencer dut (
        .clk             (clk),
        .rstn            (rstn),
        .host_wr_valid   (host_wr_valid),
        .host_wr_ready   (host_wr_ready),
        .host_wr_addr    (host_wr_addr),
        .host_wr_data    (host_wr_data),
        .start           (start),
        .abort           (abort),
        .target_frames   (target_frames),
        .total_frames    (total_frames),
        .probability_idx (probability_idx),
        .probability_in  (probability_in),
        .sim_en          (sim_en),
        .sim_rstn        (sim_rstn),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Model of the start timeline: index presented at a given offset.
    function automatic logic [31:0] exp_idx(input int t);
        if (t >= 1 + RST && t < 1 + RST + N) return 32'(t - 1 - RST);
        return PARK;
    endfunction

    function automatic logic in_load(input int t);
        return (t >= 1 + RST && t < 1 + RST + N);
    endfunction

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic host_write(input int addr, input logic [63:0] data);
        host_wr_valid = 1'b1;
        host_wr_addr  = addr[5:0];
        host_wr_data  = data;
        cycle();
        host_wr_valid = 1'b0;
        ref_table[addr] = data;
    endtask

    // Pulses start with the given target; returns at offset 1.
    task automatic pulse_start(input logic [63:0] target);
        target_frames = target;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic go_idle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        cycle();
        #1;
        checks++; if (status !== ST_IDLE) begin failures++; $display("[TB] FAIL reset_status: got %b expected %b", status, ST_IDLE); end
        checks++; if (probability_idx !== PARK) begin failures++; $display("[TB] FAIL reset_idx: got %h expected %h", probability_idx, PARK); end
        checks++; if (probability_in !== 64'd0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", probability_in); end
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        // Reset asserted in the middle of LOAD must clear outputs at once.
        pulse_start(64'd0);
        repeat (19) cycle();
        checks++; if (probability_idx !== exp_idx(20)) begin failures++; $display("[TB] FAIL midload_idx: got %h expected %h", probability_idx, exp_idx(20)); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (status !== ST_IDLE) begin failures++; $display("[TB] FAIL async_reset_status: got %b expected %b", status, ST_IDLE); end
        checks++; if (probability_idx !== PARK) begin failures++; $display("[TB] FAIL async_reset_idx: got %h expected %h", probability_idx, PARK); end
        checks++; if (probability_in !== 64'd0) begin failures++; $display("[TB] FAIL async_reset_data: got %h expected 0", probability_in); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            cycle();
            checks++; if (status !== ST_IDLE) begin failures++; $display("[TB] FAIL post_reset_idle: got %b expected %b", status, ST_IDLE); end
        end
    endtask

    task automatic test_load_sequence();
        logic [4:0] exp_st;
        for (int i = 0; i < N; i++) host_write(i, 64'hA5A5_0000_0000_0000 + 64'(i));
        total_frames = '1;
        pulse_start(64'd0);
        // The target was latched; later changes to the input must not matter.
        target_frames = 64'd1;
        for (int t = 1; t <= RUN_T; t++) begin
            exp_st = (t == RUN_T) ? ST_RUN : {2'b00, 1'b1, 1'b0, ~in_load(t)};
            checks++; if (status !== exp_st) begin failures++; $display("[TB] FAIL seq_status t=%0d: got %b expected %b", t, status, exp_st); end
            checks++; if (probability_idx !== exp_idx(t)) begin failures++; $display("[TB] FAIL seq_idx t=%0d: got %h expected %h", t, probability_idx, exp_idx(t)); end
            if (in_load(t)) begin
                checks++; if (probability_in !== ref_table[t - 1 - RST]) begin failures++; $display("[TB] FAIL seq_data t=%0d: got %h expected %h", t, probability_in, ref_table[t - 1 - RST]); end
            end
            if (t < RUN_T) cycle();
        end
        repeat (5) begin
            cycle();
            checks++; if (status !== ST_RUN) begin failures++; $display("[TB] FAIL zero_target_runs: got %b expected %b", status, ST_RUN); end
        end
        go_idle();
        checks++; if (status !== ST_IDLE) begin failures++; $display("[TB] FAIL abort_from_run: got %b expected %b", status, ST_IDLE); end
    endtask

    // mode 0: frames +1 every 10 RUN cycles; mode 1: random +0..3 per cycle.
    task automatic test_run_to_target(input logic [63:0] target, input logic [63:0] init_frames, input int mode);
        logic [63:0] frames;
        logic        reached;
        logic        got_done;
        frames   = init_frames;
        reached  = 1'b0;
        got_done = 1'b0;
        total_frames = frames;
        pulse_start(target);
        repeat (RUN_T - 1) cycle();
        for (int i = 0; i < 5000; i++) begin
            if (reached) begin
                checks++; if (status !== ST_DONE) begin failures++; $display("[TB] FAIL target_done: got %b expected %b", status, ST_DONE); end
                got_done = 1'b1;
                break;
            end
            checks++; if (status !== ST_RUN) begin failures++; $display("[TB] FAIL target_running i=%0d: got %b expected %b", i, status, ST_RUN); end
            if (mode == 0) begin
                if (i % 10 == 9) frames = frames + 64'd1;
            end else begin
                frames = frames + 64'($urandom_range(0, 3));
            end
            total_frames = frames;
            if (frames >= target) reached = 1'b1;
            cycle();
        end
        checks++; if (!got_done) begin failures++; $display("[TB] FAIL target_timeout: got running expected done within 5000 cycles"); end
        repeat (4) begin
            total_frames = total_frames + 64'd1;
            cycle();
            checks++; if (status !== ST_DONE) begin failures++; $display("[TB] FAIL done_held: got %b expected %b", status, ST_DONE); end
        end
    endtask

    task automatic test_reload();
        int a;
        checks++; if (status !== ST_DONE) begin failures++; $display("[TB] FAIL reload_precond: got %b expected %b", status, ST_DONE); end
        host_write(5, 64'd1);
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, N - 1);
            if (a == 5) a = 6;
            host_write(a, {$urandom, $urandom});
        end
        pulse_start(64'd0);
        checks++; if (status !== 5'b00101) begin failures++; $display("[TB] FAIL reload_restart: got %b expected 00101", status); end
        for (int t = 1; t < RUN_T; t++) begin
            if (in_load(t)) begin
                checks++; if (probability_in !== ref_table[t - 1 - RST]) begin failures++; $display("[TB] FAIL reload_data t=%0d: got %h expected %h", t, probability_in, ref_table[t - 1 - RST]); end
            end
            cycle();
        end
        checks++; if (status !== ST_RUN) begin failures++; $display("[TB] FAIL reload_run: got %b expected %b", status, ST_RUN); end
        go_idle();
    endtask

    task automatic test_abort();
        pulse_start(64'd0);
        repeat (34) cycle();
        checks++; if (probability_idx !== 32'd30) begin failures++; $display("[TB] FAIL abort_at_idx: got %h expected %h", probability_idx, 32'd30); end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++; if (status !== ST_IDLE) begin failures++; $display("[TB] FAIL abort_status: got %b expected %b", status, ST_IDLE); end
        checks++; if (probability_idx !== PARK) begin failures++; $display("[TB] FAIL abort_idx: got %h expected %h", probability_idx, PARK); end
        checks++; if (probability_in !== ref_table[30]) begin failures++; $display("[TB] FAIL abort_data_held: got %h expected %h", probability_in, ref_table[30]); end
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) begin
            checks++; if (status !== ST_IDLE || probability_idx !== PARK) begin failures++; $display("[TB] FAIL start_abort_same: got %b/%h expected %b/%h", status, probability_idx, ST_IDLE, PARK); end
            cycle();
        end
    endtask

    task automatic test_ready_and_ignored_start();
        logic [63:0] new_val;
        logic [63:0] old_val;
        new_val = {$urandom, $urandom};
        old_val = ref_table[7];
        pulse_start(64'd0);
        repeat (RST) cycle();
        host_wr_valid = 1'b1;
        host_wr_addr  = 6'd7;
        host_wr_data  = new_val;
        for (int t = 1 + RST; t < 1 + RST + N; t++) begin
            checks++; if (host_wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL ready_in_load t=%0d: got %b expected 0", t, host_wr_ready); end
            if (t == 1 + RST + 7) begin
                checks++; if (probability_in !== old_val) begin failures++; $display("[TB] FAIL blocked_write_data: got %h expected %h", probability_in, old_val); end
            end
            cycle();
        end
        checks++; if (host_wr_ready !== 1'b1 || probability_idx !== PARK) begin failures++; $display("[TB] FAIL park_ready: got %b/%h expected 1/%h", host_wr_ready, probability_idx, PARK); end
        cycle();
        host_wr_valid = 1'b0;
        ref_table[7] = new_val;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) begin
            checks++; if (status !== ST_RUN || probability_idx !== PARK) begin failures++; $display("[TB] FAIL start_in_run_ignored: got %b/%h expected %b/%h", status, probability_idx, ST_RUN, PARK); end
            cycle();
        end
        go_idle();
        pulse_start(64'd0);
        repeat (RST + 7) cycle();
        checks++; if (probability_in !== new_val) begin failures++; $display("[TB] FAIL park_write_landed: got %h expected %h", probability_in, new_val); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_load_sequence();
        test_run_to_target(64'd100, 64'd0, 0);
        test_reload();
        test_abort();
        test_ready_and_ignored_start();
        test_run_to_target(64'($urandom_range(1, 40)), 64'd0, 1);
        test_run_to_target(64'h8000_0000_0000_0001, 64'hF000_0000_0000_0000, 0);
        go_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
